// File: rtl/instr_decode_seq.sv
// -----------------------------------------------------------------------------
// instr_decode_seq
//   Consumer side of the datapath control-word interface. Accepts one 16-bit
//   instruction word over a valid/ready handshake and walks it through
//   DECODE -> EXEC -> WB. It drives the register read selects, ALU op,
//   immediate, carry-in and a one-hot register write enable into the datapath.
//
//   State table
//     state    | meaning
//     S_IDLE   | waiting for a word, in_ready_o high
//     S_DECODE | word captured, operand controls valid
//     S_EXEC   | datapath working, held here while exec_stall_i is high
//     S_WB     | write-back: reg_en/flags_en/done/illegal pulse for one cycle
//
// Ports
//   clk_i, reset_i     clock (rising edge), asynchronous active-high reset
//   in_valid_i/instr_i instruction handshake input; in_ready_o high only in IDLE
//   exec_stall_i       datapath busy, only looked at in EXEC
//   flags_i            datapath flags, flags_i[3] = carry
//   rd_a_sel_o, rd_b_sel_o, alu_op_o, imm_sel_o, imm_o, cin_o
//                      operand controls, valid DECODE..WB, zero in IDLE
//   reg_en_o, flags_en_o, done_o, illegal_o
//                      one-cycle write-back pulses
//   instr_count_o      retired instructions (illegal ones included), wraps
//
// Configuration macro
//   DECODE_CARRY_EN    adds a carry register loaded from flags_i[3] on a WB
//                      that latches flags; ADDC then drives it onto cin_o.
//                      Without it cin_o is 0 and ADDC runs as ADD.
// -----------------------------------------------------------------------------
module instr_decode_seq #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int COUNT_W  = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                in_valid_i,
    input  logic [DATA_W-1:0]   instr_i,
    output logic                in_ready_o,
    input  logic                exec_stall_i,
    input  logic [4:0]          flags_i,
    output logic [3:0]          rd_a_sel_o,
    output logic [3:0]          rd_b_sel_o,
    output logic [3:0]          alu_op_o,
    output logic                imm_sel_o,
    output logic [DATA_W-1:0]   imm_o,
    output logic                cin_o,
    output logic [NUM_REGS-1:0] reg_en_o,
    output logic                flags_en_o,
    output logic                done_o,
    output logic                illegal_o,
    output logic [COUNT_W-1:0]  instr_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

    typedef struct packed {
        logic [3:0]        rd_a;
        logic [3:0]        rd_b;
        logic [3:0]        alu_op;
        logic              imm_sel;
        logic [DATA_W-1:0] imm;
        logic              addc;
        logic              wr;
        logic              fl;
        logic              ill;
    } dec_t;

    function automatic dec_t decode_word(input logic [DATA_W-1:0] w);
        dec_t d;
        d      = '0;
        d.rd_a = w[11:8];
        d.rd_b = w[3:0];
        if (w[15:12] == 4'b0000) begin
            case (w[7:4])
                4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1001: begin
                    d.alu_op = w[7:4];
                    d.wr     = 1'b1;
                    d.fl     = 1'b1;
                end
                4'b0111: begin
`ifdef DECODE_CARRY_EN
                    d.alu_op = 4'b0111;
`else
                    d.alu_op = 4'b0101;
`endif
                    d.addc   = 1'b1;
                    d.wr     = 1'b1;
                    d.fl     = 1'b1;
                end
                4'b1011: begin
                    d.alu_op = w[7:4];
                    d.fl     = 1'b1;
                end
                4'b1101: begin
                    d.alu_op = w[7:4];
                    d.wr     = 1'b1;
                end
                default: d.ill = 1'b1;
            endcase
        end else begin
            case (w[15:12])
                4'b0101, 4'b1001, 4'b1011, 4'b1101: begin
                    d.alu_op  = w[15:12];
                    d.imm_sel = 1'b1;
                    // 8-bit immediate is {A field, ext field}, sign-extended.
                    d.imm     = {{(DATA_W-8){w[11]}}, w[11:4]};
                    d.wr      = (w[15:12] != 4'b1011);
                    d.fl      = (w[15:12] != 4'b1101);
                end
                default: d.ill = 1'b1;
            endcase
        end
        return d;
    endfunction

    state_t              state_q;
    logic                in_ready_q;
    logic [3:0]          rd_a_sel_q, rd_b_sel_q, alu_op_q;
    logic                imm_sel_q, cin_q;
    logic [DATA_W-1:0]   imm_q;
    logic [NUM_REGS-1:0] reg_en_q;
    logic                flags_en_q, done_q, illegal_q;
    logic [COUNT_W-1:0]  instr_count_q;
    // Write-back controls of the held word, decoded once at accept.
    logic                hold_wr_q, hold_fl_q, hold_ill_q;

    dec_t                dec_d;
    logic [NUM_REGS-1:0] wr_onehot;
    logic                carry_cur;

    assign dec_d     = decode_word(instr_i);
    assign wr_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << rd_b_sel_q;

`ifdef DECODE_CARRY_EN
    logic carry_q;
    logic unused_flags;
    assign carry_cur    = carry_q;
    assign unused_flags = ^{flags_i[4], flags_i[2:0]};
`else
    logic unused_flags;
    assign carry_cur    = 1'b0;
    assign unused_flags = ^flags_i;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b1;
            rd_a_sel_q    <= '0;
            rd_b_sel_q    <= '0;
            alu_op_q      <= '0;
            imm_sel_q     <= 1'b0;
            imm_q         <= '0;
            cin_q         <= 1'b0;
            reg_en_q      <= '0;
            flags_en_q    <= 1'b0;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
            hold_wr_q     <= 1'b0;
            hold_fl_q     <= 1'b0;
            hold_ill_q    <= 1'b0;
`ifdef DECODE_CARRY_EN
            carry_q       <= 1'b0;
`endif
        end else begin
            reg_en_q   <= '0;
            flags_en_q <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        state_q    <= S_DECODE;
                        in_ready_q <= 1'b0;
                        rd_a_sel_q <= dec_d.rd_a;
                        rd_b_sel_q <= dec_d.rd_b;
                        alu_op_q   <= dec_d.alu_op;
                        imm_sel_q  <= dec_d.imm_sel;
                        imm_q      <= dec_d.imm;
                        cin_q      <= dec_d.addc & carry_cur;
                        hold_wr_q  <= dec_d.wr;
                        hold_fl_q  <= dec_d.fl;
                        hold_ill_q <= dec_d.ill;
                    end
                end
                S_DECODE: state_q <= S_EXEC;
                S_EXEC: begin
                    if (!exec_stall_i) begin
                        state_q    <= S_WB;
                        reg_en_q   <= hold_wr_q ? wr_onehot : '0;
                        flags_en_q <= hold_fl_q;
                        illegal_q  <= hold_ill_q;
                        done_q     <= 1'b1;
                    end
                end
                S_WB: begin
                    state_q       <= S_IDLE;
                    in_ready_q    <= 1'b1;
                    rd_a_sel_q    <= '0;
                    rd_b_sel_q    <= '0;
                    alu_op_q      <= '0;
                    imm_sel_q     <= 1'b0;
                    imm_q         <= '0;
                    cin_q         <= 1'b0;
                    instr_count_q <= instr_count_q + COUNT_W'(1);
`ifdef DECODE_CARRY_EN
                    if (flags_en_q) carry_q <= flags_i[3];
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o    = in_ready_q;
    assign rd_a_sel_o    = rd_a_sel_q;
    assign rd_b_sel_o    = rd_b_sel_q;
    assign alu_op_o      = alu_op_q;
    assign imm_sel_o     = imm_sel_q;
    assign imm_o         = imm_q;
    assign cin_o         = cin_q;
    assign reg_en_o      = reg_en_q;
    assign flags_en_o    = flags_en_q;
    assign done_o        = done_q;
    assign illegal_o     = illegal_q;
    assign instr_count_o = instr_count_q;

endmodule

// File: tb/tb_instr_decode_seq.sv
`timescale 1ns/1ps
module tb_instr_decode_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] instr;
    logic        in_ready;
    logic        exec_stall;
    logic [4:0]  flags;
    logic [3:0]  rd_a_sel, rd_b_sel, alu_op;
    logic        imm_sel, cin, flags_en, done, illegal;
    logic [15:0] imm, reg_en, instr_count;

    always #5 clk = ~clk;

    instr_decode_seq dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .in_valid_i    (in_valid),
        .instr_i       (instr),
        .in_ready_o    (in_ready),
        .exec_stall_i  (exec_stall),
        .flags_i       (flags),
        .rd_a_sel_o    (rd_a_sel),
        .rd_b_sel_o    (rd_b_sel),
        .alu_op_o      (alu_op),
        .imm_sel_o     (imm_sel),
        .imm_o         (imm),
        .cin_o         (cin),
        .reg_en_o      (reg_en),
        .flags_en_o    (flags_en),
        .done_o        (done),
        .illegal_o     (illegal),
        .instr_count_o (instr_count)
    );

`ifdef DECODE_CARRY_EN
    localparam bit CARRY_EN = 1'b1;
`else
    localparam bit CARRY_EN = 1'b0;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] count_m  = '0;
    logic        carry_m  = 1'b0;

    typedef struct packed {
        logic [3:0]  a, b, alu;
        logic        imm_sel;
        logic [15:0] imm;
        logic        cin;
        logic [15:0] reg_en;
        logic        flags_en;
        logic        illegal;
    } exp_t;

    typedef struct {
        int          wb_cyc;
        int          done_cnt;
        int          reg_pulses;
        int          ready_bad;
        int          unstable;
        bit          idle_ok;
        logic [3:0]  a, b, alu;
        logic        imm_sel;
        logic [15:0] imm;
        logic        cin;
        logic [15:0] reg_en;
        logic        flags_en;
        logic        illegal;
        logic [15:0] count_after;
    } obs_t;

    // Reference: instruction-set rules written directly from the field map.
    function automatic exp_t model(input logic [15:0] w, input logic c);
        exp_t       e;
        logic [3:0] op, ext;
        bit         r_ok, i_ok;
        e    = '0;
        op   = w[15:12];
        ext  = w[7:4];
        r_ok = (op == 4'd0) && (ext inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13});
        i_ok = op inside {4'd5, 4'd9, 4'd11, 4'd13};
        e.a  = w[11:8];
        e.b  = w[3:0];
        if (r_ok) begin
            e.alu      = (ext == 4'd7 && !CARRY_EN) ? 4'd5 : ext;
            e.cin      = (ext == 4'd7) ? (c & CARRY_EN) : 1'b0;
            e.reg_en   = (ext == 4'd11) ? 16'h0 : (16'h0001 << w[3:0]);
            e.flags_en = (ext != 4'd13);
        end else if (i_ok) begin
            e.alu      = op;
            e.imm_sel  = 1'b1;
            e.imm      = {{8{w[11]}}, w[11:4]};
            e.reg_en   = (op == 4'd11) ? 16'h0 : (16'h0001 << w[3:0]);
            e.flags_en = (op != 4'd13);
        end else begin
            e.illegal  = 1'b1;
        end
        return e;
    endfunction

    // Drives one word and records what the DUT shows in every cycle after accept.
    task automatic run_instr(input logic [15:0] w, input int stall, input logic [4:0] fl,
                             input bit hold, output obs_t o);
        int guard;
        o = '{wb_cyc: -1, default: 0};
        @(negedge clk);
        instr = w; in_valid = 1'b1; flags = fl; exec_stall = (stall > 0);
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        for (int k = 1; k <= stall + 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                o.a = rd_a_sel; o.b = rd_b_sel; o.alu = alu_op;
                o.imm_sel = imm_sel; o.imm = imm; o.cin = cin;
            end else if (o.wb_cyc < 0 || k == o.wb_cyc) begin
                if ({o.a, o.b, o.alu, o.imm_sel, o.imm, o.cin} !==
                    {rd_a_sel, rd_b_sel, alu_op, imm_sel, imm, cin}) o.unstable++;
            end
            if (o.wb_cyc >= 0 && k == o.wb_cyc + 1) begin
                o.idle_ok = in_ready && ({rd_a_sel, rd_b_sel, alu_op, imm_sel, imm, cin,
                                          reg_en, flags_en, done, illegal} == '0);
                o.count_after = instr_count;
                break;
            end
            if (in_ready) o.ready_bad++;
            if (reg_en != 16'h0) o.reg_pulses++;
            if (done) begin
                o.done_cnt++;
                if (o.wb_cyc < 0) begin
                    o.wb_cyc = k; o.reg_en = reg_en; o.flags_en = flags_en; o.illegal = illegal;
                end
                in_valid = 1'b0;
            end
            if (!hold && k == 1) begin
                in_valid = 1'b0;
                instr = 16'($urandom);
            end
            exec_stall = (stall > 0) && (k <= stall + 1);
        end
        in_valid = 1'b0;
        exec_stall = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; instr = 16'h0; exec_stall = 1'b0; flags = 5'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b exp=1", in_ready);
        end
        checks++;
        if ({rd_a_sel, rd_b_sel, alu_op, imm_sel, imm, cin, reg_en, flags_en, done, illegal} !== '0) begin
            failures++; $display("FAIL reset_outputs got a=%h b=%h op=%h imm=%h reg_en=%h done=%b exp all 0",
                                 rd_a_sel, rd_b_sel, alu_op, imm, reg_en, done);
        end
        checks++;
        if (instr_count !== 16'h0) begin
            failures++; $display("FAIL reset_count got=%h exp=0", instr_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_add();
        obs_t o;
        run_instr(16'h0151, 0, 5'h0, 1'b0, o);
        count_m++;
        checks++;
        if ({o.a, o.b, o.alu} !== {4'd1, 4'd1, 4'd5}) begin
            failures++; $display("FAIL add_operands got a=%h b=%h op=%h exp 1 1 5", o.a, o.b, o.alu);
        end
        checks++;
        if (o.wb_cyc !== 3) begin
            failures++; $display("FAIL add_latency got=%0d exp=3", o.wb_cyc);
        end
        checks++;
        if (o.reg_en !== 16'h0002 || o.reg_pulses !== 1 || o.done_cnt !== 1) begin
            failures++; $display("FAIL add_wb got reg_en=%h pulses=%0d done=%0d exp 0002 1 1",
                                 o.reg_en, o.reg_pulses, o.done_cnt);
        end
        checks++;
        if (o.count_after !== count_m) begin
            failures++; $display("FAIL add_count got=%h exp=%h", o.count_after, count_m);
        end
    endtask

    task automatic test_addi();
        obs_t o;
        run_instr(16'h5AFF, 0, 5'h0, 1'b0, o);
        count_m++;
        checks++;
        if (o.imm_sel !== 1'b1 || o.imm !== 16'hFFAF || o.alu !== 4'd5) begin
            failures++; $display("FAIL addi_imm got sel=%b imm=%h op=%h exp 1 FFAF 5", o.imm_sel, o.imm, o.alu);
        end
        checks++;
        if (o.reg_en !== 16'h8000 || o.flags_en !== 1'b1) begin
            failures++; $display("FAIL addi_wb got reg_en=%h fe=%b exp 8000 1", o.reg_en, o.flags_en);
        end
    endtask

    task automatic test_cmp_illegal();
        obs_t o;
        run_instr(16'h01B2, 0, 5'h0, 1'b0, o);
        count_m++;
        checks++;
        if (o.reg_en !== 16'h0 || o.reg_pulses !== 0 || o.flags_en !== 1'b1 || o.done_cnt !== 1) begin
            failures++; $display("FAIL cmp_wb got reg_en=%h pulses=%0d fe=%b done=%0d exp 0 0 1 1",
                                 o.reg_en, o.reg_pulses, o.flags_en, o.done_cnt);
        end
        run_instr(16'hF000, 0, 5'h0, 1'b0, o);
        count_m++;
        checks++;
        if (o.illegal !== 1'b1 || o.reg_pulses !== 0 || o.flags_en !== 1'b0 || o.done_cnt !== 1) begin
            failures++; $display("FAIL illegal_wb got ill=%b pulses=%0d fe=%b done=%0d exp 1 0 0 1",
                                 o.illegal, o.reg_pulses, o.flags_en, o.done_cnt);
        end
        checks++;
        if (o.count_after !== count_m) begin
            failures++; $display("FAIL illegal_count got=%h exp=%h", o.count_after, count_m);
        end
    endtask

    task automatic test_stall();
        obs_t o;
        run_instr(16'h0151, 5, 5'h0, 1'b1, o);
        count_m++;
        checks++;
        if (o.wb_cyc !== 8) begin
            failures++; $display("FAIL stall_latency got=%0d exp=8", o.wb_cyc);
        end
        checks++;
        if (o.done_cnt !== 1 || o.ready_bad !== 0 || o.unstable !== 0) begin
            failures++; $display("FAIL stall_single got done=%0d ready_bad=%0d unstable=%0d exp 1 0 0",
                                 o.done_cnt, o.ready_bad, o.unstable);
        end
        checks++;
        if (o.count_after !== count_m || !o.idle_ok) begin
            failures++; $display("FAIL stall_count got=%h idle_ok=%b exp %h 1", o.count_after, o.idle_ok, count_m);
        end
    endtask

    task automatic test_carry();
        obs_t o;
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            logic c_in;
            c_in = (pass == 0);
            run_instr(16'h01B2, 0, {1'b0, c_in, 3'b000}, 1'b0, o);
            count_m++;
            carry_m = c_in;
            e = model(16'h0172, carry_m);
            run_instr(16'h0172, 0, 5'h0, 1'b0, o);
            count_m++;
            carry_m = 1'b0;
            checks++;
            if (o.cin !== e.cin || o.alu !== e.alu) begin
                failures++; $display("FAIL carry_addc%0d got cin=%b op=%h exp %b %h", pass, o.cin, o.alu, e.cin, e.alu);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clk);
        instr = 16'h0151; in_valid = 1'b1; exec_stall = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || rd_a_sel !== 4'd1) begin
            failures++; $display("FAIL midexec_busy got ready=%b a=%h exp 0 1", in_ready, rd_a_sel);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || {rd_a_sel, rd_b_sel, alu_op, imm_sel, imm, cin,
                                  reg_en, flags_en, done, illegal} !== '0) begin
            failures++; $display("FAIL midreset_outputs got ready=%b a=%h b=%h op=%h exp ready=1 rest 0",
                                 in_ready, rd_a_sel, rd_b_sel, alu_op);
        end
        checks++;
        if (instr_count !== 16'h0) begin
            failures++; $display("FAIL midreset_count got=%h exp=0", instr_count);
        end
        @(negedge clk);
        reset = 1'b0; exec_stall = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (reg_en !== 16'h0 || done !== 1'b0) pulses++;
        end
        checks++;
        if (pulses !== 0 || instr_count !== 16'h0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL midreset_after got pulses=%0d count=%h ready=%b exp 0 0 1",
                                 pulses, instr_count, in_ready);
        end
        count_m = '0;
        carry_m = 1'b0;
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        logic [15:0] w;
        logic [4:0]  fl;
        int          stall;
        logic [3:0]  r_ext [8] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13};
        logic [3:0]  i_op  [4] = '{4'd5, 4'd9, 4'd11, 4'd13};
        for (int n = 0; n < 60; n++) begin
            w = 16'($urandom);
            case ($urandom_range(0, 3))
                0: w = {4'd0, w[11:8], r_ext[$urandom_range(0, 7)], w[3:0]};
                1: w = {i_op[$urandom_range(0, 3)], w[11:0]};
                2: w = {4'd0, w[11:0]};
                default: ;
            endcase
            fl    = 5'($urandom);
            stall = $urandom_range(0, 3);
            e     = model(w, carry_m);
            run_instr(w, stall, fl, 1'($urandom), o);
            count_m++;
            if (e.flags_en) carry_m = fl[3];
            checks++;
            if (o.wb_cyc !== 3 + stall || o.done_cnt !== 1 || o.ready_bad !== 0 || o.unstable !== 0 || !o.idle_ok) begin
                failures++; $display("FAIL rnd_seq w=%h got wb=%0d done=%0d rb=%0d unst=%0d idle=%b exp wb=%0d 1 0 0 1",
                                     w, o.wb_cyc, o.done_cnt, o.ready_bad, o.unstable, o.idle_ok, 3 + stall);
            end
            checks++;
            if (o.reg_en !== e.reg_en || o.flags_en !== e.flags_en || o.illegal !== e.illegal ||
                o.reg_pulses !== int'(e.reg_en != 16'h0)) begin
                failures++; $display("FAIL rnd_wb w=%h got reg_en=%h fe=%b ill=%b pulses=%0d exp %h %b %b",
                                     w, o.reg_en, o.flags_en, o.illegal, o.reg_pulses, e.reg_en, e.flags_en, e.illegal);
            end
            if (!e.illegal) begin
                checks++;
                if ({o.a, o.b, o.alu, o.imm_sel, o.imm, o.cin} !== {e.a, e.b, e.alu, e.imm_sel, e.imm, e.cin}) begin
                    failures++; $display("FAIL rnd_ops w=%h got a=%h b=%h op=%h is=%b imm=%h cin=%b exp %h %h %h %b %h %b",
                                         w, o.a, o.b, o.alu, o.imm_sel, o.imm, o.cin,
                                         e.a, e.b, e.alu, e.imm_sel, e.imm, e.cin);
                end
            end
            checks++;
            if (o.count_after !== count_m) begin
                failures++; $display("FAIL rnd_count w=%h got=%h exp=%h", w, o.count_after, count_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi();
        test_cmp_illegal();
        test_stall();
        test_carry();
        test_reset_mid();
        test_random();
        test_carry();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
